romulus_rho_stream: RTL and testbench

//  Parametrised streaming state block for Romulus; next generation of the fixed-bus state updater.

---
 rtl/romulus_stream_pkg.sv | 26 ++
 rtl/romulus_rho_slice.sv | 56 +++++
 rtl/romulus_rho_stream.sv | 167 ++++++++++++++++
 tb/tb_romulus_rho_stream.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/romulus_stream_pkg.sv
// Shared definitions for the Romulus streaming state block: mode codes,
// FSM state codes, counter widths and the G byte map used by rho.
package romulus_stream_pkg;

  localparam logic [1:0] MODE_AD  = 2'b00;
  localparam logic [1:0] MODE_ENC = 2'b01;
  localparam logic [1:0] MODE_DEC = 2'b10;
  localparam logic [1:0] MODE_TAG = 2'b11;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RHO  = 3'd1;
  localparam logic [2:0] ST_PAD  = 3'd2;
  localparam logic [2:0] ST_TBC  = 3'd3;
  localparam logic [2:0] ST_TAG  = 3'd4;

  localparam int DEF_BUSW   = 32;
  localparam int DEF_STATEW = 128;
  localparam int DEF_BEATS  = DEF_STATEW / DEF_BUSW;
  // Block byte count (up to STATEW/8 <= 31) always fits here
  localparam int CNTW       = 5;

  function automatic logic [7:0] gmatrix(input logic [7:0] b);
    return {b[0] ^ b[7], b[7:1]};
  endfunction

endpackage

// File: rtl/romulus_rho_slice.sv
// Combinational per-beat rho: G on the state slice, mode-dependent message,
// byte masking of partial beats and insertion of the pad length byte.
module romulus_rho_slice
  import romulus_stream_pkg::*;
#(
  parameter int BUSW = 32,
  parameter int BW   = $clog2(BUSW/8) + 1
) (
  input  logic [BUSW-1:0] s,
  input  logic [BUSW-1:0] data,
  input  logic            dec,
  input  logic            pad,
  input  logic            last,
  input  logic [BW-1:0]   bytes,
  input  logic            final_beat,
  input  logic [CNTW-1:0] byte_cnt,
  output logic [BUSW-1:0] slice_next,
  output logic [BUSW-1:0] out_word,
  output logic [CNTW-1:0] byte_total
);

  localparam int BPB = BUSW / 8;

  logic [BW-1:0]   nb;
  logic [BUSW-1:0] gs;
  logic [BUSW-1:0] msg;

  // Out-of-range byte counts on a last beat are treated as a full beat
  always_comb begin
    nb = BW'(BPB);
    if (pad)
      nb = '0;
    else if (last && bytes != '0 && bytes <= BW'(BPB))
      nb = bytes;
  end

  always_comb begin
    gs       = '0;
    msg      = '0;
    out_word = '0;
    for (int i = 0; i < BPB; i++)
      gs[BUSW-1-8*i -: 8] = gmatrix(s[BUSW-1-8*i -: 8]);
    for (int i = 0; i < BPB; i++) begin
      if (i < int'(nb)) begin
        out_word[BUSW-1-8*i -: 8] = data[BUSW-1-8*i -: 8] ^ gs[BUSW-1-8*i -: 8];
        msg[BUSW-1-8*i -: 8]      = dec ? out_word[BUSW-1-8*i -: 8] : data[BUSW-1-8*i -: 8];
      end
    end
    byte_total = byte_cnt + CNTW'(nb);
    // A short final beat of the block carries the Romulus length byte
    if (final_beat && nb != BW'(BPB))
      msg[7:0] = 8'(byte_total);
    slice_next = s ^ msg;
  end

endmodule

// File: rtl/romulus_rho_stream.sv
// Romulus streaming state block: rho per bus beat, padding, TBC handoff and
// a registered pdo stage. ROMULUS_TAG_OUT_EN enables the TAG output mode.
module romulus_rho_stream
  import romulus_stream_pkg::*;
#(
  parameter int BUSW   = 32,
  parameter int STATEW = 128
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic                    clr,
  input  logic [BUSW-1:0]         pdi_data,
  input  logic                    pdi_valid,
  output logic                    pdi_ready,
  input  logic                    pdi_last,
  input  logic [$clog2(BUSW/8):0] pdi_bytes,
  output logic [BUSW-1:0]         pdo_data,
  output logic                    pdo_valid,
  input  logic                    pdo_ready,
  output logic                    tbc_req,
  input  logic                    tbc_done,
  input  logic [STATEW-1:0]       tbc_state_i,
  output logic [STATEW-1:0]       state_o,
  output logic                    busy
);

  localparam int BEATS = STATEW / BUSW;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [2:0]        fsm;
  logic [1:0]        mode_q;
  logic [STATEW-1:0] state;
  logic [BCW-1:0]    beat_cnt;
  logic [CNTW-1:0]   byte_cnt;
  logic [BUSW-1:0]   slice_next;
  logic [BUSW-1:0]   out_word;
  logic [CNTW-1:0]   byte_total;
  logic              final_beat;
  logic              pdo_free;
  logic              accept;

  assign pdo_free   = !pdo_valid || pdo_ready;
  assign pdi_ready  = (fsm == ST_RHO) && pdo_free;
  assign accept     = pdi_valid && pdi_ready;
  assign final_beat = (beat_cnt == BCW'(BEATS-1));
  assign tbc_req    = (fsm == ST_TBC);
  assign busy       = (fsm != ST_IDLE);
  assign state_o    = state;

  romulus_rho_slice #(.BUSW(BUSW)) u_slice (
    .s          (state[STATEW-1 -: BUSW]),
    .data       (pdi_data),
    .dec        (mode_q == MODE_DEC),
    .pad        (fsm == ST_PAD),
    .last       (pdi_last),
    .bytes      (pdi_bytes),
    .final_beat (final_beat),
    .byte_cnt   (byte_cnt),
    .slice_next (slice_next),
    .out_word   (out_word),
    .byte_total (byte_total)
  );

`ifdef ROMULUS_TAG_OUT_EN
  logic [BUSW-1:0] tag_word;

  always_comb begin
    tag_word = '0;
    for (int i = 0; i < BUSW/8; i++)
      tag_word[BUSW-1-8*i -: 8] = gmatrix(state[STATEW-1-8*i -: 8]);
  end
`endif

  // The state rotates one slice per beat so it is realigned after BEATS beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm      <= ST_IDLE;
      mode_q   <= MODE_AD;
      state    <= '0;
      beat_cnt <= '0;
      byte_cnt <= '0;
    end else begin
      case (fsm)
        ST_IDLE: begin
          if (clr)
            state <= '0;
          if (start) begin
            mode_q <= mode;
`ifdef ROMULUS_TAG_OUT_EN
            fsm <= (mode == MODE_TAG) ? ST_TAG : ST_RHO;
`else
            fsm <= ST_RHO;
`endif
          end
        end
        ST_RHO: begin
          if (accept) begin
            state    <= {state[STATEW-BUSW-1:0], slice_next};
            byte_cnt <= byte_total;
            if (final_beat) begin
              fsm      <= ST_TBC;
              beat_cnt <= '0;
              byte_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + BCW'(1);
              if (pdi_last)
                fsm <= ST_PAD;
            end
          end
        end
        ST_PAD: begin
          state <= {state[STATEW-BUSW-1:0], slice_next};
          if (final_beat) begin
            fsm      <= ST_TBC;
            beat_cnt <= '0;
            byte_cnt <= '0;
          end else begin
            beat_cnt <= beat_cnt + BCW'(1);
          end
        end
        ST_TBC: begin
          if (tbc_done) begin
            state <= tbc_state_i;
            fsm   <= ST_IDLE;
          end
        end
`ifdef ROMULUS_TAG_OUT_EN
        ST_TAG: begin
          if (pdo_free) begin
            state <= {state[STATEW-BUSW-1:0], state[STATEW-1 -: BUSW]};
            if (final_beat) begin
              fsm      <= ST_IDLE;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + BCW'(1);
            end
          end
        end
`endif
        default: fsm <= ST_IDLE;
      endcase
    end
  end

  // A new beat replaces a draining one in the same cycle, so no bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pdo_valid <= 1'b0;
      pdo_data  <= '0;
    end else if (accept && (mode_q == MODE_ENC || mode_q == MODE_DEC)) begin
      pdo_valid <= 1'b1;
      pdo_data  <= out_word;
    end
`ifdef ROMULUS_TAG_OUT_EN
    else if (fsm == ST_TAG && pdo_free) begin
      pdo_valid <= 1'b1;
      pdo_data  <= tag_word;
    end
`endif
    else if (pdo_ready) begin
      pdo_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_romulus_rho_stream.sv
// Self-checking bench for romulus_rho_stream: table of block vectors plus
// hand sequences for backpressure, clr, reset and (optionally) TAG output.
module tb_romulus_rho_stream;

  localparam logic [1:0] M_AD  = 2'b00;
  localparam logic [1:0] M_ENC = 2'b01;
  localparam logic [1:0] M_DEC = 2'b10;
  localparam logic [1:0] M_TAG = 2'b11;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   mode;
  logic         clr;
  logic [31:0]  pdi_data;
  logic         pdi_valid;
  logic         pdi_ready;
  logic         pdi_last;
  logic [2:0]   pdi_bytes;
  logic [31:0]  pdo_data;
  logic         pdo_valid;
  logic         pdo_ready;
  logic         tbc_req;
  logic         tbc_done;
  logic [127:0] tbc_state_i;
  logic [127:0] state_o;
  logic         busy;

  int total = 0;
  int bad   = 0;
  logic [31:0]  exp_q [$];
  logic [127:0] last_load;

  typedef struct packed {
    logic [1:0]       mode;
    logic [127:0]     init;
    logic [3:0][31:0] beat;
    logic [2:0]       nbeats;
    logic             last_flag;
    logic [2:0]       last_bytes;
    logic [3:0][31:0] pdo;
    logic [127:0]     state;
  } vec_t;

  vec_t vecs [$];

  romulus_rho_stream dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .mode        (mode),
    .clr         (clr),
    .pdi_data    (pdi_data),
    .pdi_valid   (pdi_valid),
    .pdi_ready   (pdi_ready),
    .pdi_last    (pdi_last),
    .pdi_bytes   (pdi_bytes),
    .pdo_data    (pdo_data),
    .pdo_valid   (pdo_valid),
    .pdo_ready   (pdo_ready),
    .tbc_req     (tbc_req),
    .tbc_done    (tbc_done),
    .tbc_state_i (tbc_state_i),
    .state_o     (state_o),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic vec_t mk(input logic [1:0] m, input logic [127:0] init,
                              input logic [31:0] b0, input logic [31:0] b1,
                              input logic [31:0] b2, input logic [31:0] b3,
                              input logic [2:0] nbeats, input logic last_flag,
                              input logic [2:0] last_bytes,
                              input logic [31:0] p0, input logic [31:0] p1,
                              input logic [31:0] p2, input logic [31:0] p3,
                              input logic [127:0] st);
    vec_t v;
    v.mode = m; v.init = init;
    v.beat[0] = b0; v.beat[1] = b1; v.beat[2] = b2; v.beat[3] = b3;
    v.nbeats = nbeats; v.last_flag = last_flag; v.last_bytes = last_bytes;
    v.pdo[0] = p0; v.pdo[1] = p1; v.pdo[2] = p2; v.pdo[3] = p3;
    v.state = st;
    return v;
  endfunction

  // Scoreboard: every transferred pdo beat must match the oldest expectation
  always @(negedge clk) begin
    if (pdo_valid && pdo_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL pdo_unexpected: got %h expected no beat", pdo_data);
      end else begin
        check("pdo_beat", pdo_data, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (pdi_valid && pdi_ready && pdi_last)
      assert (pdi_bytes >= 3'd1 && pdi_bytes <= 3'd4)
        else $error("[TB] illegal pdi_bytes %0d on last beat", pdi_bytes);
  end

  task automatic pulse_start(input logic [1:0] m);
    mode = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last, input logic [2:0] nb,
                           input logic push, input logic [31:0] exp);
    int n = 0;
    pdi_data = d; pdi_valid = 1'b1; pdi_last = last; pdi_bytes = nb;
    @(negedge clk);
    while (!pdi_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("pdi_accept", pdi_ready, 1'b1);
    if (push) exp_q.push_back(exp);
    @(posedge clk); #1;
    pdi_valid = 1'b0; pdi_last = 1'b0; pdi_bytes = 3'd4;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      n++;
      @(negedge clk);
    end
    check({name, "_drain"}, exp_q.size(), 0);
  endtask

  task automatic finish_tbc(input string name, input logic [127:0] exp_state, input logic [127:0] load);
    int n = 0;
    @(negedge clk);
    while (!tbc_req && n < 40) begin
      n++;
      @(negedge clk);
    end
    check({name, "_tbc_req"}, tbc_req, 1'b1);
    check({name, "_pdi_ready_tbc"}, pdi_ready, 1'b0);
    check({name, "_state"}, state_o, exp_state);
    drain(name);
    @(posedge clk); #1;
    tbc_state_i = load;
    tbc_done = 1'b1;
    @(posedge clk); #1;
    tbc_done = 1'b0;
    last_load = load;
    check({name, "_loaded"}, state_o, load);
    check({name, "_idle"}, busy, 1'b0);
  endtask

  task automatic prime(input logic [127:0] init);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    pulse_start(M_AD);
    for (int i = 0; i < 4; i++) send_beat(32'h0, 1'b0, 3'd4, 1'b0, 32'h0);
    finish_tbc("prime", 128'h0, init);
  endtask

  task automatic run_vector(input vec_t v, input int idx);
    logic is_last;
    logic push;
    prime(v.init);
    pulse_start(v.mode);
    push = (v.mode == M_ENC) || (v.mode == M_DEC);
    for (int i = 0; i < int'(v.nbeats); i++) begin
      is_last = v.last_flag && (i == int'(v.nbeats) - 1);
      send_beat(v.beat[i], is_last, is_last ? v.last_bytes : 3'd4, push, v.pdo[i]);
    end
    finish_tbc($sformatf("vec%0d", idx), v.state, {$urandom, $urandom, $urandom, $urandom});
  endtask

  task automatic check_reset(input string name);
    check({name, "_pdo_valid"}, pdo_valid, 1'b0);
    check({name, "_pdo_data"}, pdo_data, 32'h0);
    check({name, "_pdi_ready"}, pdi_ready, 1'b0);
    check({name, "_tbc_req"}, tbc_req, 1'b0);
    check({name, "_busy"}, busy, 1'b0);
    check({name, "_state"}, state_o, 128'h0);
  endtask

  initial begin
    int n;
    logic saw_req;
    rst_n = 1'b0; start = 1'b0; mode = M_AD; clr = 1'b0;
    pdi_data = '0; pdi_valid = 1'b0; pdi_last = 1'b0; pdi_bytes = 3'd4;
    pdo_ready = 1'b1; tbc_done = 1'b0; tbc_state_i = '0; last_load = '0;

    repeat (2) @(negedge clk);
    check_reset("por");
    @(posedge clk); #1;
    rst_n = 1'b1;

    vecs.push_back(mk(M_ENC, 128'h0,
      32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF, 3'd4, 1'b1, 3'd4,
      32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF,
      128'h00112233_44556677_8899AABB_CCDDEEFF));
    vecs.push_back(mk(M_ENC, {16{8'h0F}},
      32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF, 3'd4, 1'b1, 3'd4,
      32'h8796A5B4, 32'hC3D2E1F0, 32'h0F1E2D3C, 32'h4B5A6978,
      128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0));
    vecs.push_back(mk(M_DEC, {16{8'h0F}},
      32'h8796A5B4, 32'hC3D2E1F0, 32'h0F1E2D3C, 32'h4B5A6978, 3'd4, 1'b1, 3'd4,
      32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF,
      128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0));
    vecs.push_back(mk(M_AD, 128'h0,
      32'h00112233, 32'h44AABBCC, 32'h0, 32'h0, 3'd2, 1'b1, 3'd1,
      32'h0, 32'h0, 32'h0, 32'h0,
      128'h00112233_44000000_00000000_00000005));
    vecs.push_back(mk(M_ENC, 128'h0,
      32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF, 3'd4, 1'b1, 3'd2,
      32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDD0000,
      128'h00112233_44556677_8899AABB_CCDD000E));
    vecs.push_back(mk(M_ENC, {16{8'h80}},
      32'h01FF0FAA, 32'h0, 32'h0, 32'h0, 3'd1, 1'b1, 3'd3,
      32'hC13FCF00, 32'h0, 32'h0, 32'h0,
      128'h817F8F80_80808080_80808080_80808083));
    vecs.push_back(mk(M_AD, 128'h0,
      32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'h0F0F0F0F, 3'd4, 1'b0, 3'd4,
      32'h0, 32'h0, 32'h0, 32'h0,
      128'hDEADBEEF_01234567_89ABCDEF_0F0F0F0F));
`ifndef ROMULUS_TAG_OUT_EN
    vecs.push_back(mk(M_TAG, 128'h0,
      32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'h0F0F0F0F, 3'd4, 1'b0, 3'd4,
      32'h0, 32'h0, 32'h0, 32'h0,
      128'hDEADBEEF_01234567_89ABCDEF_0F0F0F0F));
`endif

    for (int i = 0; i < vecs.size(); i++) run_vector(vecs[i], i);

    // tbc_done in IDLE must not disturb the state; clr zeroes it
    tbc_state_i = 128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5;
    tbc_done = 1'b1;
    @(posedge clk); #1;
    tbc_done = 1'b0;
    check("idle_tbc_done_ignored", state_o, last_load);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check("clr_state", state_o, 128'h0);

    // Backpressure: pdo_ready low for 3 cycles after beat 0, then in TBC
    pulse_start(M_ENC);
    send_beat(32'h00112233, 1'b0, 3'd4, 1'b1, 32'h00112233);
    pdo_ready = 1'b0;
    fork
      send_beat(32'h44556677, 1'b0, 3'd4, 1'b1, 32'h44556677);
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("bp_pdi_ready", pdi_ready, 1'b0);
          check("bp_pdo_valid", pdo_valid, 1'b1);
          check("bp_pdo_data", pdo_data, 32'h00112233);
        end
        @(posedge clk); #1;
        pdo_ready = 1'b1;
      end
    join
    send_beat(32'h8899AABB, 1'b0, 3'd4, 1'b1, 32'h8899AABB);
    send_beat(32'hCCDDEEFF, 1'b0, 3'd4, 1'b1, 32'hCCDDEEFF);
    pdo_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("bp_tbc_pdo_valid", pdo_valid, 1'b1);
      check("bp_tbc_pdo_data", pdo_data, 32'hCCDDEEFF);
      check("bp_tbc_req", tbc_req, 1'b1);
    end
    @(posedge clk); #1;
    pdo_ready = 1'b1;
    finish_tbc("bp", 128'h00112233_44556677_8899AABB_CCDDEEFF, 128'h0);

    // Asynchronous reset while padding with a pdo beat pending
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    pulse_start(M_ENC);
    send_beat(32'h11223344, 1'b1, 3'd2, 1'b1, 32'h11220000);
    check("pad_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_reset("rst_pad");
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_vector(vecs[0], 100);

    // Asynchronous reset while waiting on the cipher
    pulse_start(M_AD);
    for (int i = 0; i < 4; i++) send_beat(32'h5A5A5A5A, 1'b0, 3'd4, 1'b0, 32'h0);
    n = 0;
    @(negedge clk);
    while (!tbc_req && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("rst_tbc_req_seen", tbc_req, 1'b1);
    #1 rst_n = 1'b0;
    #1 check_reset("rst_tbc");
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_vector(vecs[3], 101);

`ifdef ROMULUS_TAG_OUT_EN
    prime({16{8'h80}});
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hC0C0C0C0);
    pulse_start(M_TAG);
    n = 0;
    saw_req = 1'b0;
    while (busy && n < 40) begin
      @(negedge clk);
      if (tbc_req) saw_req = 1'b1;
      n++;
    end
    check("tag_done", busy, 1'b0);
    check("tag_no_tbc_req", saw_req, 1'b0);
    drain("tag");
    check("tag_state", state_o, {16{8'h80}});
    @(posedge clk); #1;
`else
    saw_req = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
